// File: rtl/cfg_arb_pkg.sv
// Shared types and default sizing for the configuration-register arbiter.
package cfg_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        SCRUB = 2'd2
    } arbState_e;

    localparam int DEF_N_REQ        = 4;
    localparam int DEF_W            = 8;
    localparam int DEF_SCRUB_PERIOD = 16;

endpackage

// File: rtl/cfg_reg_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [PW-1:0] winner,
    output logic          valid
);

    logic [PW-1:0] idx;

    // Walk from the lowest priority offset upward so the nearest hit wins last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr) + i) % N);
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cfg_reg_arbiter.sv
// Shared configuration register with round-robin write arbitration and periodic
// scrub; all state is held in three voted copies.
//
// state | meaning
// IDLE  | evaluate scrub_due first, then pending requests
// WRITE | grant pulse to winner, q loads latched data at closing edge
// SCRUB | q copies reload from the voted value, scrub pulse
module cfg_reg_arbiter
    import cfg_arb_pkg::*;
#(
    parameter int N_REQ        = DEF_N_REQ,
    parameter int W            = DEF_W,
    parameter int SCRUB_PERIOD = DEF_SCRUB_PERIOD
) (
    input  logic               c,
    input  logic               rstn,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] wdata,
    output logic [N_REQ-1:0]   gnt,
    output logic [W-1:0]       q,
    output logic               busy,
    output logic               scrub
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(SCRUB_PERIOD);
    localparam int SW = 2 + PW + CW + 1 + W + N_REQ;

    logic [SW-1:0]    ctlCopy [3];
    logic [SW-1:0]    ctlVote;
    logic [SW-1:0]    ctlNext;
    logic [W-1:0]     qCopy [3];
    logic [W-1:0]     qCopyNext [3];
    logic [W-1:0]     qVote;
    logic [2:0]       seuHit;

    logic [1:0]       stateBits;
    arbState_e        state;
    arbState_e        stateNext;
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptrNext;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cntNext;
    logic             scrubDue;
    logic             scrubDueNext;
    logic [W-1:0]     latData;
    logic [W-1:0]     latDataNext;
    logic [N_REQ-1:0] gntR;
    logic [N_REQ-1:0] gntNext;
    logic [PW-1:0]    winner;
    logic             winValid;
    logic             wrap;

    // Upset injection hook: flips the selected q copy; tied off in silicon.
    assign seuHit = '0;

    assign ctlVote = (ctlCopy[0] & ctlCopy[1]) | (ctlCopy[0] & ctlCopy[2]) | (ctlCopy[1] & ctlCopy[2]);
    assign qVote   = (qCopy[0] & qCopy[1]) | (qCopy[0] & qCopy[2]) | (qCopy[1] & qCopy[2]);

    assign {stateBits, ptr, cnt, scrubDue, latData, gntR} = ctlVote;
    assign state   = arbState_e'(stateBits);
    assign ctlNext = {stateNext, ptrNext, cntNext, scrubDueNext, latDataNext, gntNext};

    rr_pick #(.N(N_REQ), .PW(PW)) uPick (
        .req    (req),
        .ptr    (ptr),
        .winner (winner),
        .valid  (winValid)
    );

    always_comb begin
        stateNext    = IDLE;
        ptrNext      = ptr;
        latDataNext  = latData;
        gntNext      = '0;
        wrap         = (cnt == CW'(SCRUB_PERIOD - 1));
        cntNext      = wrap ? '0 : cnt + CW'(1);
        scrubDueNext = scrubDue | wrap;
        case (state)
            IDLE: begin
                if (scrubDue) begin
                    stateNext    = SCRUB;
                    scrubDueNext = wrap;
                end else if (winValid) begin
                    stateNext       = WRITE;
                    gntNext[winner] = 1'b1;
                    for (int i = 0; i < N_REQ; i++) begin
                        if (winner == PW'(i)) begin
                            latDataNext = wdata[i*W +: W];
                        end
                    end
                    ptrNext = (winner == PW'(N_REQ - 1)) ? '0 : winner + PW'(1);
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Outside WRITE/SCRUB each q copy holds itself, so an upset persists until scrub.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            qCopyNext[k] = qCopy[k];
            if (state == WRITE) begin
                qCopyNext[k] = latData;
            end else if (state == SCRUB) begin
                qCopyNext[k] = qVote;
            end
        end
    end

    always_ff @(posedge c or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < 3; k++) begin
                ctlCopy[k] <= '0;
                qCopy[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                ctlCopy[k] <= ctlNext;
                qCopy[k]   <= qCopyNext[k] ^ {W{seuHit[k]}};
            end
        end
    end

    assign gnt   = gntR;
    assign q     = qVote;
    assign busy  = (state != IDLE);
    assign scrub = (state == SCRUB);

endmodule
